// File: rtl/hit_det_pkg.sv
// -----------------------------------------------------------------------------
// hit_det_pkg
// Shared definitions for the multi-object collision detector.
//   hit_state_t : scan controller state encoding (IDLE, SCAN, REPORT)
//   KIND_*      : meaning of one obj_kind bit
// -----------------------------------------------------------------------------
package hit_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SCAN   = 2'b01,
      REPORT = 2'b10
   } hit_state_t;

   localparam logic KIND_POLICE = 1'b0;
   localparam logic KIND_COIN   = 1'b1;

endpackage

// File: rtl/hit_overlap_cmp.sv
// -----------------------------------------------------------------------------
// hit_overlap_cmp
// Combinational 1-D interval overlap test between [a_x, a_x+a_w) and
// [b_x, b_x+b_w). Touching edges do not count as an overlap.
// Ports:
//   a_x, a_w : left edge and width of interval A
//   b_x, b_w : left edge and width of interval B
//   overlap  : 1 when the two half-open intervals intersect
// -----------------------------------------------------------------------------
module hit_overlap_cmp #(
   parameter int X_W = 8
) (
   input  logic [X_W-1:0] a_x,
   input  logic [X_W-1:0] a_w,
   input  logic [X_W-1:0] b_x,
   input  logic [X_W-1:0] b_w,
   output logic           overlap
);

   // Right edges carry one extra bit so objects near the right border of the
   // screen never wrap back to a small coordinate.
   logic [X_W:0] a_end;
   logic [X_W:0] b_end;

   assign a_end   = {1'b0, a_x} + {1'b0, a_w};
   assign b_end   = {1'b0, b_x} + {1'b0, b_w};
   assign overlap = ({1'b0, a_x} < b_end) && ({1'b0, b_x} < a_end);

endmodule

// File: rtl/multi_hit_detector.sv
// -----------------------------------------------------------------------------
// multi_hit_detector
// Collision detector between the player car and N_OBJ objects (coins/police).
// One object channel is checked per clock; at the end of every completed scan
// a one-cycle report is emitted. Each overlap fires only once until the object
// stops overlapping (edge-armed per channel).
// Ports:
//   CLOCK_50   : system clock (rising edge)
//   resetn     : asynchronous active-low reset
//   EnterEn    : game running; starts/continues scanning, low aborts a scan
//   x_car      : car left x
//   obj_x      : packed object left x, channel i at [i*X_W +: X_W]
//   obj_y      : packed object y, channel i at [i*Y_W +: Y_W]
//   obj_valid  : object present on screen
//   obj_kind   : 1 = coin, 0 = police
//   CoinEn     : 1-cycle pulse, new coin hit(s) this frame
//   PoliceEn   : 1-cycle pulse, new police hit(s) this frame
//   hit_mask   : channels newly hit, valid while frame_done is high
//   frame_done : 1-cycle pulse at the end of every completed scan
//   coin_count : saturating coin hit count
//   pol_count  : saturating police hit count
// Build option: define HIT_DET_COUNTERS_EN to build the hit counters;
// otherwise coin_count/pol_count are constant 0.
// -----------------------------------------------------------------------------
module multi_hit_detector
   import hit_det_pkg::*;
#(
   parameter int N_OBJ  = 4,
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int CAR_Y  = 70,
   parameter int CAR_W  = 20,
   parameter int POL_W  = 20,
   parameter int COIN_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic                   EnterEn,
   input  logic [X_W-1:0]         x_car,
   input  logic [N_OBJ*X_W-1:0]   obj_x,
   input  logic [N_OBJ*Y_W-1:0]   obj_y,
   input  logic [N_OBJ-1:0]       obj_valid,
   input  logic [N_OBJ-1:0]       obj_kind,
   output logic                   CoinEn,
   output logic                   PoliceEn,
   output logic [N_OBJ-1:0]       hit_mask,
   output logic                   frame_done,
   output logic [CNT_W-1:0]       coin_count,
   output logic [CNT_W-1:0]       pol_count
);

   localparam int               IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
   localparam logic [Y_W-1:0]   CAR_Y_V  = Y_W'(CAR_Y);
   localparam logic [X_W-1:0]   CAR_W_V  = X_W'(CAR_W);
   localparam logic [X_W-1:0]   POL_W_V  = X_W'(POL_W);
   localparam logic [X_W-1:0]   COIN_W_V = X_W'(COIN_W);

   hit_state_t       state_reg,   state_next;
   logic [IDX_W-1:0] idx_reg,     idx_next;
   logic [N_OBJ-1:0] pending_reg, pending_next;
   logic [N_OBJ-1:0] armed_reg,   armed_next;
   logic             coin_en_next, police_en_next, frame_done_next;
   logic [N_OBJ-1:0] hit_mask_next;

   // Unpack the flat coordinate buses so the current channel is a plain index.
   logic [X_W-1:0] ch_x [N_OBJ];
   logic [Y_W-1:0] ch_y [N_OBJ];

   genvar gi;
   generate
      for (gi = 0; gi < N_OBJ; gi++) begin : g_unpack
         assign ch_x[gi] = obj_x[gi*X_W +: X_W];
         assign ch_y[gi] = obj_y[gi*Y_W +: Y_W];
      end
   endgenerate

   logic [X_W-1:0] sel_x;
   logic [Y_W-1:0] sel_y;
   logic [X_W-1:0] sel_w;
   logic           x_overlap;
   logic           overlap;

   assign sel_x = ch_x[idx_reg];
   assign sel_y = ch_y[idx_reg];
   assign sel_w = (obj_kind[idx_reg] == KIND_COIN) ? COIN_W_V : POL_W_V;

   hit_overlap_cmp #(.X_W(X_W)) u_cmp (
      .a_x     (x_car),
      .a_w     (CAR_W_V),
      .b_x     (sel_x),
      .b_w     (sel_w),
      .overlap (x_overlap)
   );

   assign overlap = obj_valid[idx_reg] && (sel_y == CAR_Y_V) && x_overlap;

   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      pending_next    = pending_reg;
      armed_next      = armed_reg;
      coin_en_next    = 1'b0;
      police_en_next  = 1'b0;
      hit_mask_next   = '0;
      frame_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            idx_next     = '0;
            pending_next = '0;
            if (EnterEn) state_next = SCAN;
         end

         SCAN: begin
            if (!EnterEn) begin
               // Abort: the partial frame is dropped, arming history survives.
               state_next   = IDLE;
               idx_next     = '0;
               pending_next = '0;
            end else begin
               if (overlap) begin
                  if (armed_reg[idx_reg]) begin
                     pending_next[idx_reg] = 1'b1;
                     armed_next[idx_reg]   = 1'b0;
                  end
               end else begin
                  armed_next[idx_reg] = 1'b1;
               end

               if (idx_reg == LAST_IDX) begin
                  // Report outputs are registered on entry to REPORT so they
                  // are high exactly during the REPORT cycle.
                  state_next      = REPORT;
                  idx_next        = '0;
                  frame_done_next = 1'b1;
                  hit_mask_next   = pending_next;
                  coin_en_next    = |(pending_next & obj_kind);
                  police_en_next  = |(pending_next & ~obj_kind);
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end

         REPORT: begin
            state_next   = EnterEn ? SCAN : IDLE;
            idx_next     = '0;
            pending_next = '0;
         end

         default: begin
            state_next   = IDLE;
            idx_next     = '0;
            pending_next = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         pending_reg <= '0;
         armed_reg   <= '1;
         CoinEn      <= 1'b0;
         PoliceEn    <= 1'b0;
         hit_mask    <= '0;
         frame_done  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         pending_reg <= pending_next;
         armed_reg   <= armed_next;
         CoinEn      <= coin_en_next;
         PoliceEn    <= police_en_next;
         hit_mask    <= hit_mask_next;
         frame_done  <= frame_done_next;
      end
   end

`ifdef HIT_DET_COUNTERS_EN
   localparam int               SUM_W   = CNT_W + 6;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic [4:0]       coin_pop, pol_pop;
   logic [SUM_W-1:0] coin_sum, pol_sum;
   logic [CNT_W-1:0] coin_count_next, pol_count_next;

   // Counted together with the pulses, from the same final pending vector.
   always_comb begin
      coin_pop = '0;
      pol_pop  = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         coin_pop = coin_pop + {4'b0, pending_next[i] &  obj_kind[i]};
         pol_pop  = pol_pop  + {4'b0, pending_next[i] & ~obj_kind[i]};
      end
      coin_sum        = SUM_W'(coin_count) + SUM_W'(coin_pop);
      pol_sum         = SUM_W'(pol_count)  + SUM_W'(pol_pop);
      coin_count_next = coin_count;
      pol_count_next  = pol_count;
      if (frame_done_next) begin
         coin_count_next = (coin_sum > CNT_MAX) ? {CNT_W{1'b1}} : coin_sum[CNT_W-1:0];
         pol_count_next  = (pol_sum  > CNT_MAX) ? {CNT_W{1'b1}} : pol_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         coin_count <= '0;
         pol_count  <= '0;
      end else begin
         coin_count <= coin_count_next;
         pol_count  <= pol_count_next;
      end
   end
`else
   assign coin_count = '0;
   assign pol_count  = '0;
`endif

endmodule
